aes_sbox_share_sched: RTL

Time-multiplexes a small pool of composite-field S-box lanes between two requesters: the round datapath and the key schedule. The round datapath issues SubBytes or InvSubBytes on a 128-bit state. The key schedule issues forward SubWord on a 32-bit word. The block arbitrates between them, sequences the state through the lanes in chunks, and returns results over valid/ready handshakes. It sits between the round controller and the key-expansion unit, replacing 20 dedicated S-boxes with SBOX_LANES shared ones.

---
 rtl/aes_sched_pkg.sv | 35 +++
 rtl/aes_sbox_composite_field.sv | 39 +++
 rtl/aes_sbox_share_sched.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the shared S-box scheduler.
// Latency: none (declarations and a combinational helper only).
// Backpressure: not applicable.
package aes_sched_pkg;

    localparam int AES_STATE_BYTES = 16;
    localparam int AES_WORD_BYTES  = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DAT_RUN = 3'd1,
        S_DAT_RSP = 3'd2,
        S_KEY_RUN = 3'd3,
        S_KEY_RSP = 3'd4
    } fsm_e;

    typedef enum logic {
        GNT_DAT = 1'b0,
        GNT_KEY = 1'b1
    } gnt_e;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1, shift-and-add form.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_sbox_composite_field.sv
// Single AES S-box lane, forward (enc_dec=1) or inverse (enc_dec=0).
// Latency: purely combinational.
// Backpressure: none; output follows input every cycle.
module aes_sbox_composite_field
    import aes_sched_pkg::*;
(
    input  logic [7:0] data_in,
    input  logic       enc_dec,
    output logic [7:0] data_out
);

    logic [7:0] w_pre;
    logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60, w_x120, w_x240, w_inv;
    logic [7:0] w_fwd;

    // Inverse direction undoes the affine map before inversion.
    assign w_pre = enc_dec ? data_in
                           : ({data_in[6:0], data_in[7]} ^ {data_in[4:0], data_in[7:5]} ^
                              {data_in[1:0], data_in[7:2]} ^ 8'h05);

    // Multiplicative inverse as x^254 (0 maps to 0); 254 = 240 + 12 + 2.
    assign w_x2   = gf_mul(w_pre, w_pre);
    assign w_x3   = gf_mul(w_x2, w_pre);
    assign w_x6   = gf_mul(w_x3, w_x3);
    assign w_x12  = gf_mul(w_x6, w_x6);
    assign w_x15  = gf_mul(w_x12, w_x3);
    assign w_x30  = gf_mul(w_x15, w_x15);
    assign w_x60  = gf_mul(w_x30, w_x30);
    assign w_x120 = gf_mul(w_x60, w_x60);
    assign w_x240 = gf_mul(w_x120, w_x120);
    assign w_inv  = gf_mul(gf_mul(w_x240, w_x12), w_x2);

    // Forward affine map applied after inversion.
    assign w_fwd = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]} ^
                   {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;

    assign data_out = enc_dec ? w_fwd : w_inv;

endmodule

// File: rtl/aes_sbox_share_sched.sv
// Shares SBOX_LANES S-box lanes between the round datapath (128-bit state) and key schedule (32-bit SubWord).
// Latency: state result valid DAT_CHUNKS+1 cycles after accept, key result KEY_CHUNKS+1 cycles after accept.
// Backpressure: results held until rsp_ready; no new request is accepted until the pending result is taken.
module aes_sbox_share_sched
    import aes_sched_pkg::*;
#(
    parameter int SBOX_LANES = 4
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         dat_req_valid,
    output logic         dat_req_ready,
    input  logic         dat_req_enc,
    input  logic [127:0] dat_req_state,
    output logic         dat_rsp_valid,
    input  logic         dat_rsp_ready,
    output logic [127:0] dat_rsp_state,
    input  logic         key_req_valid,
    output logic         key_req_ready,
    input  logic [31:0]  key_req_word,
    output logic         key_rsp_valid,
    input  logic         key_rsp_ready,
    output logic [31:0]  key_rsp_word,
    output logic         busy
);

    localparam int DAT_CHUNKS = AES_STATE_BYTES / SBOX_LANES;
    localparam int KEY_LANES  = (SBOX_LANES < AES_WORD_BYTES) ? SBOX_LANES : AES_WORD_BYTES;
    localparam int KEY_CHUNKS = AES_WORD_BYTES / KEY_LANES;
    localparam int CNT_W      = (DAT_CHUNKS > 1) ? $clog2(DAT_CHUNKS) : 1;
    localparam int KCNT_W     = (KEY_CHUNKS > 1) ? $clog2(KEY_CHUNKS) : 1;

    generate
        if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
              SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
            $error("aes_sbox_share_sched: SBOX_LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    fsm_e                                     r_fsm, w_fsm_nxt;
    gnt_e                                     r_last_gnt;
    logic [CNT_W-1:0]                         r_cnt;
    logic                                     r_enc;
    logic [DAT_CHUNKS-1:0][SBOX_LANES-1:0][7:0] r_dat_in, r_dat_out;
    logic [KEY_CHUNKS-1:0][KEY_LANES-1:0][7:0]  r_key_in, r_key_out;
    logic [SBOX_LANES-1:0][7:0]               w_lane_in, w_lane_out;
    logic                                     w_lane_enc;
    logic [KCNT_W-1:0]                        w_kcnt;
    logic                                     w_last_chunk;
    logic                                     w_gnt_dat, w_gnt_key;

    assign w_kcnt       = r_cnt[KCNT_W-1:0];
    assign w_last_chunk = (r_fsm == S_DAT_RUN) ? (r_cnt == CNT_W'(DAT_CHUNKS - 1))
                                               : (w_kcnt == KCNT_W'(KEY_CHUNKS - 1));

    // Chunk mux: route the active chunk of the captured operand onto the lanes.
    always_comb begin
        w_lane_in  = '0;
        w_lane_enc = r_enc;
        if (r_fsm == S_DAT_RUN) begin
            w_lane_in = r_dat_in[r_cnt];
        end else if (r_fsm == S_KEY_RUN) begin
            w_lane_in[KEY_LANES-1:0] = r_key_in[w_kcnt];
            w_lane_enc               = 1'b1;
        end
    end

    generate
        for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
            aes_sbox_composite_field u_sbox (
                .data_in  (w_lane_in[j]),
                .enc_dec  (w_lane_enc),
                .data_out (w_lane_out[j])
            );
        end
    endgenerate

    // Arbitration, handshake readys and next-state decode.
    always_comb begin
        w_fsm_nxt     = r_fsm;
        w_gnt_dat     = dat_req_valid && (!key_req_valid || (r_last_gnt == GNT_KEY));
        w_gnt_key     = key_req_valid && (!dat_req_valid || (r_last_gnt == GNT_DAT));
        dat_req_ready = (r_fsm == S_IDLE) && !rst && w_gnt_dat;
        key_req_ready = (r_fsm == S_IDLE) && !rst && w_gnt_key;
        dat_rsp_valid = (r_fsm == S_DAT_RSP);
        key_rsp_valid = (r_fsm == S_KEY_RSP);
        busy          = (r_fsm != S_IDLE);
        case (r_fsm)
            S_IDLE: begin
                if (dat_req_ready)      w_fsm_nxt = S_DAT_RUN;
                else if (key_req_ready) w_fsm_nxt = S_KEY_RUN;
            end
            S_DAT_RUN: if (w_last_chunk)  w_fsm_nxt = S_DAT_RSP;
            S_KEY_RUN: if (w_last_chunk)  w_fsm_nxt = S_KEY_RSP;
            S_DAT_RSP: if (dat_rsp_ready) w_fsm_nxt = S_IDLE;
            S_KEY_RSP: if (key_rsp_ready) w_fsm_nxt = S_IDLE;
            default:                      w_fsm_nxt = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_fsm <= S_IDLE;
        else     r_fsm <= w_fsm_nxt;
    end

    // Request capture, chunk counter and result demux into the response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_last_gnt <= GNT_KEY;
            r_enc      <= 1'b0;
            r_dat_in   <= '0;
            r_key_in   <= '0;
            r_dat_out  <= '0;
            r_key_out  <= '0;
        end else begin
            if (dat_req_valid && dat_req_ready) begin
                r_dat_in   <= dat_req_state;
                r_enc      <= dat_req_enc;
                r_last_gnt <= GNT_DAT;
                r_cnt      <= '0;
            end else if (key_req_valid && key_req_ready) begin
                r_key_in   <= key_req_word;
                r_last_gnt <= GNT_KEY;
                r_cnt      <= '0;
            end
            if (r_fsm == S_DAT_RUN) begin
                r_dat_out[r_cnt] <= w_lane_out;
                r_cnt            <= w_last_chunk ? '0 : r_cnt + 1'b1;
            end
            if (r_fsm == S_KEY_RUN) begin
                r_key_out[w_kcnt] <= w_lane_out[KEY_LANES-1:0];
                r_cnt             <= w_last_chunk ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign dat_rsp_state = r_dat_out;
    assign key_rsp_word  = r_key_out;

endmodule
